frame_transmit: RTL and testbench
=================================

# frame_transmit

Serial frame transmitter for the project's single-wire frame protocol; it is the sending end of the link that the frame receiver decodes. On a `start` request it latches a frame size and up to 16 data bytes, then serialises a start bit, the 4-bit frame size, the data bytes and an 8-bit CRC, and ends with a stop bit. Every bit is driven on `TX` for a programmable number of clock cycles.

## Interface
- No parameters. The bit period comes from the `baudrate` port.
- `clk`  input  1  System clock. All state changes on its rising edge.
- `reset`  input  1  Reset. Asynchronous, active-high.
- `start`  input  1  Frame request. Sampled only in IDLE.
- `baudrate`  input  8  Bit period minus one. Each bit lasts `baudrate+1` cycles. Latched on accept.
- `framesize`  input  4  Number of data bytes minus one. Latched on accept.
- `framedata`  input  128  Payload. Byte k is `framedata[127-8k -: 8]`, for k = 0..15. Latched on accept.
- `TX`  output  1  Serial line. Idle level is 0.
- `busy`  output  1  High from the accept cycle until the end of the stop bit.
- `done`  output  1  One-cycle pulse when the stop bit completes.
- `crcout`  output  8  Running CRC register. Holds the final CRC after the frame.

## Operation
- States:
  - IDLE: `TX`=0.
  - START: `TX`=1.
  - SIZE: 4 bits of `framesize`, MSB first.
  - DATA: bytes k=0..framesize, each sent MSB first.
  - CRC: 8 bits of `crcout`, MSB first.
  - STOP: `TX`=0.
- IDLE & `start` → latch inputs, clear CRC to 0x00, set `busy`, go to START. `TX` changes on the next edge.
- `start` asserted while `busy` is ignored. There is no queueing.
- A bit counter runs from 0 to the latched `baudrate`. On reaching the terminal count the next bit is presented and the counter returns to 0.
- Index counters:
  - Size index counts 3→0.
  - Bit index counts 7→0.
  - Byte counter counts 0→framesize. DATA ends after the byte with index equal to `framesize` has been sent. `framesize`=15 sends all 128 bits with no wrap.
- CRC:
  - Polynomial x^8+x^2+x+1 (0x07), initial value 0x00, no final XOR.
  - Per transmitted bit b: `fb = crc[7]^b`, then `crc = {crc[6:0],1'b0} ^ (fb ? 8'h07 : 8'h00)`.
  - Updated once per bit, on the bit's final cycle. Covers SIZE and DATA bits only.
  - Frozen during the CRC state. CRC bits are shifted out from a snapshot copy.
- STOP terminal count → `done`=1 for one cycle, `busy`=0, go to IDLE.
- A new `start` is accepted from the cycle after `done`.
- Frame length in bits: N = 1 + 4 + 8·(framesize+1) + 8 + 1.

## Timing
- Reset values: `TX`=0, `busy`=0, `done`=0, `crcout`=0x00, state=IDLE, all counters 0.
- Reset asserted mid-frame: `TX` drops to 0 immediately (asynchronously). The frame is abandoned and no `done` is issued.
- Accept at edge E: `TX`=1 and `busy`=1 from E+1.
- Bit j occupies edges E+1+j·(baudrate+1) through E+(j+1)·(baudrate+1).
- `done` is high in the cycle following the last stop-bit cycle. `busy` falls in the same cycle.
- Total edges from accept to the `done` cycle: N·(baudrate+1)+1.
- `baudrate`=0 gives one cycle per bit. `baudrate`=255 gives 256 cycles per bit. Counters are 8 bits wide and do not overflow.
- All outputs are registered. No combinational path runs from any input to `TX`.

## Configuration
- `FRAME_TX_CRC_EN` defined: the CRC state is present and N includes the 8 CRC bits.
- `FRAME_TX_CRC_EN` undefined:
  - The CRC state is removed and DATA goes directly to STOP, so N is 8 bits shorter.
  - `crcout` is tied to 0x00.

## Test plan
- Reset, then `baudrate`=3, `framesize`=0, byte0=0x00, pulse `start` → `TX` shows 1, 0000, 00000000, CRC 00000000, 0, with each bit 4 cycles wide. `done` arrives 89 edges after accept. `crcout`=0x00.
- `baudrate`=0, `framesize`=0, byte0=0x01 → `TX` bits are 1,0000,00000001,00000111,0. `crcout`=0x07. `done` arrives at edge 23.
- `baudrate`=1, `framesize`=15, `framedata`=128'h0123…EF repeated → 142 bits with bytes in order 0x01,0x23,… MSB first, and size bits 1111. CRC matches the bench model. No wrap.
- `start` held high throughout the frame in the previous scenario → exactly one frame is sent. A second frame starts only after `done`, because `start` is still high in IDLE.
- Reset asserted during DATA bit 5 of byte 2 → `TX`=0, `busy`=0 and `crcout`=0 immediately. No `done`. A subsequent `start` sends a complete frame.
- Build without `FRAME_TX_CRC_EN` and repeat scenario 1 → 14 bits: 1,0000,00000000,0. `done` arrives 57 edges after accept.

Source files
------------

// File: rtl/frame_transmit.sv
// frame_transmit: serial frame transmitter for the single-wire frame link.
//
// On an accepted start request the block latches the bit period, frame size
// and payload, then sends on TX: a start bit (1), the 4-bit frame size
// (MSB first), framesize+1 data bytes (byte 0 first, each MSB first), the
// 8-bit CRC of the size and data bits (MSB first) and a stop bit (0).
// Every bit lasts baudrate+1 clock cycles.
//
// Build option: define FRAME_TX_CRC_EN to include the CRC field. Without it
// the CRC state is removed, DATA is followed directly by STOP and crcout
// reads 0x00.
//
// Ports:
//   clk        in   1    system clock, rising edge
//   reset      in   1    asynchronous active-high reset
//   start      in   1    frame request, sampled only while idle
//   baudrate   in   8    bit period minus one
//   framesize  in   4    number of data bytes minus one
//   framedata  in   128  payload, byte k = framedata[127-8k -: 8]
//   TX         out  1    serial line, idle level 0
//   busy       out  1    frame in progress
//   done       out  1    one-cycle pulse after the stop bit completes
//   crcout     out  8    running CRC, final CRC after the frame
module frame_transmit (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [7:0]   baudrate,
  input  logic [3:0]   framesize,
  input  logic [127:0] framedata,
  output logic         TX,
  output logic         busy,
  output logic         done,
  output logic [7:0]   crcout
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SIZE, S_DATA, S_CRC, S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [7:0]     baud_q, baud_d;
  logic [7:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]     idx_q, idx_d;
  logic [3:0]     byte_q, byte_d;
  logic [3:0]     size_q, size_d;
  logic [127:0]   data_q, data_d;
  logic           tx_q, tx_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           term;
  logic           cur_bit;
`ifdef FRAME_TX_CRC_EN
  logic [7:0]     crc_q, crc_d;
  logic [7:0]     snap_q, snap_d;
  logic [7:0]     crc_step;
`endif

  assign term = (bit_cnt_q == baud_q);

  // Value of the bit the FSM is currently presenting. TX is a registered
  // copy of this, so the line lags the state by exactly one cycle.
  always_comb begin
    cur_bit = 1'b0;
    case (state_q)
      S_START: cur_bit = 1'b1;
      S_SIZE:  cur_bit = size_q[idx_q[1:0]];
      S_DATA:  cur_bit = data_q[127];
`ifdef FRAME_TX_CRC_EN
      S_CRC:   cur_bit = snap_q[idx_q];
`endif
      default: cur_bit = 1'b0;
    endcase
  end

`ifdef FRAME_TX_CRC_EN
  // One step of the 0x07 CRC over the bit currently on the line.
  assign crc_step = {crc_q[6:0], 1'b0} ^ ((crc_q[7] ^ cur_bit) ? 8'h07 : 8'h00);
`endif

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    size_d    = size_q;
    data_d    = data_q;
    bit_cnt_d = (state_q == S_IDLE || term) ? 8'd0 : bit_cnt_q + 8'd1;
    tx_d      = cur_bit;
    busy_d    = (state_q != S_IDLE);
    // busy_q high while the state is already back in IDLE can only mean
    // the previous cycle was the last stop-bit cycle.
    done_d    = busy_q && (state_q == S_IDLE);
`ifdef FRAME_TX_CRC_EN
    crc_d     = crc_q;
    snap_d    = snap_q;
`endif

    case (state_q)
      S_IDLE: begin
        // Holding off while busy_q is still set keeps a held start from
        // being taken before the done pulse has been issued.
        if (start && !busy_q) begin
          state_d   = S_START;
          baud_d    = baudrate;
          size_d    = framesize;
          data_d    = framedata;
          bit_cnt_d = 8'd0;
          idx_d     = 3'd0;
          byte_d    = 4'd0;
`ifdef FRAME_TX_CRC_EN
          crc_d     = 8'h00;
`endif
        end
      end
      S_START: begin
        if (term) begin
          state_d = S_SIZE;
          idx_d   = 3'd3;
        end
      end
      S_SIZE: begin
        if (term) begin
`ifdef FRAME_TX_CRC_EN
          crc_d = crc_step;
`endif
          if (idx_q == 3'd0) begin
            state_d = S_DATA;
            idx_d   = 3'd7;
            byte_d  = 4'd0;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
      end
      S_DATA: begin
        if (term) begin
`ifdef FRAME_TX_CRC_EN
          crc_d = crc_step;
`endif
          // Payload is consumed from the top; the next bit is always [127].
          data_d = {data_q[126:0], 1'b0};
          if (idx_q == 3'd0) begin
            idx_d = 3'd7;
            if (byte_q == size_q) begin
`ifdef FRAME_TX_CRC_EN
              state_d = S_CRC;
              snap_d  = crc_step;
`else
              state_d = S_STOP;
`endif
            end else begin
              byte_d = byte_q + 4'd1;
            end
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end
      end
`ifdef FRAME_TX_CRC_EN
      S_CRC: begin
        if (term) begin
          if (idx_q == 3'd0) state_d = S_STOP;
          else               idx_d   = idx_q - 3'd1;
        end
      end
`endif
      S_STOP: begin
        if (term) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      baud_q    <= 8'd0;
      bit_cnt_q <= 8'd0;
      idx_q     <= 3'd0;
      byte_q    <= 4'd0;
      size_q    <= 4'd0;
      data_q    <= 128'd0;
      tx_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FRAME_TX_CRC_EN
      crc_q     <= 8'h00;
      snap_q    <= 8'h00;
`endif
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_cnt_q <= bit_cnt_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      size_q    <= size_d;
      data_q    <= data_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef FRAME_TX_CRC_EN
      crc_q     <= crc_d;
      snap_q    <= snap_d;
`endif
    end
  end

  assign TX   = tx_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef FRAME_TX_CRC_EN
  assign crcout = crc_q;
`else
  assign crcout = 8'h00;
`endif

endmodule

// File: tb/tb_frame_transmit.sv
// Self-checking bench for frame_transmit. Expected line bits, CRC and done
// timing are produced by a bit-level model into a scoreboard queue when a
// frame is launched and consumed cycle by cycle as the DUT drives TX.
// Honours FRAME_TX_CRC_EN the same way as the design.
module tb_frame_transmit;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [7:0]   baudrate;
  logic [3:0]   framesize;
  logic [127:0] framedata;
  logic         tx;
  logic         busy;
  logic         done;
  logic [7:0]   crcout;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int e_cyc    = 0;

  bit         exp_q[$];
  logic [7:0] exp_crc;

  localparam logic [127:0] PATTERN = 128'h0123456789ABCDEF0123456789ABCDEF;
`ifdef FRAME_TX_CRC_EN
  localparam int CRC_BITS = 8;
`else
  localparam int CRC_BITS = 0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  frame_transmit dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .baudrate  (baudrate),
    .framesize (framesize),
    .framedata (framedata),
    .TX        (tx),
    .busy      (busy),
    .done      (done),
    .crcout    (crcout)
  );

  function automatic logic [7:0] crc_bit(input logic [7:0] c, input bit b);
    bit fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  // Scoreboard producer: the full expected bit sequence of one frame.
  task automatic push_frame(input logic [3:0] fs, input logic [127:0] d);
    logic [7:0] c;
    bit b;
    c = 8'h00;
    exp_q.delete();
    exp_q.push_back(1'b1);
    for (int i = 3; i >= 0; i--) begin
      b = fs[i];
      exp_q.push_back(b);
      c = crc_bit(c, b);
    end
    for (int k = 0; k <= int'(fs); k++) begin
      for (int i = 7; i >= 0; i--) begin
        b = d[120 - 8 * k + i];
        exp_q.push_back(b);
        c = crc_bit(c, b);
      end
    end
`ifdef FRAME_TX_CRC_EN
    for (int i = 7; i >= 0; i--) exp_q.push_back(c[i]);
    exp_crc = c;
`else
    exp_crc = 8'h00;
`endif
    exp_q.push_back(1'b0);
  endtask

  // Drive a request; returns #1 after the accept edge with start still high.
  task automatic launch(input logic [7:0] b, input logic [3:0] fs, input logic [127:0] d);
    @(negedge clk);
    baudrate  = b;
    framesize = fs;
    framedata = d;
    start     = 1'b1;
    push_frame(fs, d);
    @(posedge clk);
    #1;
    e_cyc = cyc;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    baudrate = 8'd0;
    framesize = 4'd0;
    framedata = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (tx !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || crcout !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state: tx=%b busy=%b done=%b crc=%h, required 0 0 0 00", tx, busy, done, crcout);
    end
    @(negedge clk);
    reset = 1'b0;
    $display("reset released at cycle %0d", cyc);
  endtask

  task automatic test_zero_frame;
    int b;
    bit eb;
    b = 3;
    launch(8'd3, 4'd0, '0);
    start = 1'b0;
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      for (int c = 0; c <= b; c++) begin
        @(posedge clk);
        #1;
        n_checks++;
        if (tx !== eb || busy !== 1'b1 || done !== 1'b0) begin
          n_fail++;
          $display("FAIL zero_bit: cycle %0d tx=%b busy=%b done=%b, required tx=%b busy=1 done=0", cyc, tx, busy, done, eb);
        end
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0 || (cyc - e_cyc) !== (CRC_BITS == 8 ? 89 : 57)) begin
      n_fail++;
      $display("FAIL zero_done: done=%b busy=%b edges=%0d, required 1 0 %0d", done, busy, cyc - e_cyc, (CRC_BITS == 8 ? 89 : 57));
    end
    n_checks++;
    if (crcout !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_crc: crcout=%h, required 00", crcout);
    end
    $display("frame baud=3 size=0 data=00 ended at edge %0d after accept, crc=%h", cyc - e_cyc, crcout);
  endtask

  task automatic test_one_byte;
    bit eb;
    launch(8'd0, 4'd0, {8'h01, 120'd0});
    start = 1'b0;
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      @(posedge clk);
      #1;
      n_checks++;
      if (tx !== eb || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL byte01_bit: cycle %0d tx=%b busy=%b done=%b, required tx=%b busy=1 done=0", cyc, tx, busy, done, eb);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || (cyc - e_cyc) !== (CRC_BITS == 8 ? 23 : 15)) begin
      n_fail++;
      $display("FAIL byte01_done: done=%b edges=%0d, required 1 %0d", done, cyc - e_cyc, (CRC_BITS == 8 ? 23 : 15));
    end
    n_checks++;
    if (crcout !== (CRC_BITS == 8 ? 8'h07 : 8'h00)) begin
      n_fail++;
      $display("FAIL byte01_crc: crcout=%h, required %h", crcout, (CRC_BITS == 8 ? 8'h07 : 8'h00));
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL byte01_pulse: done=%b one cycle later, required 0", done);
    end
    $display("frame baud=0 size=0 data=01 ended at edge %0d after accept, crc=%h", cyc - e_cyc, crcout);
  endtask

  // Full 16-byte frame with start held high for the whole frame: exactly
  // one frame, then a second one only after the done pulse.
  task automatic test_back_to_back;
    int b;
    int skip;
    bit eb;
    bit found;
    b = 1;
    launch(8'd1, 4'd15, PATTERN);
    for (int f = 0; f < 2; f++) begin
      skip = (f == 0) ? 0 : 1;
      while (exp_q.size() > 0) begin
        eb = exp_q.pop_front();
        for (int c = skip; c <= b; c++) begin
          @(posedge clk);
          #1;
          n_checks++;
          if (tx !== eb || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL full_bit: frame %0d cycle %0d tx=%b busy=%b done=%b, required tx=%b busy=1 done=0", f, cyc, tx, busy, done, eb);
          end
        end
        skip = 0;
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b1 || busy !== 1'b0 || crcout !== exp_crc) begin
        n_fail++;
        $display("FAIL full_done: frame %0d done=%b busy=%b crc=%h, required 1 0 %h", f, done, busy, crcout, exp_crc);
      end
      $display("frame %0d baud=1 size=15 ended at edge %0d after accept, crc=%h", f, cyc - e_cyc, crcout);
      if (f == 0) begin
        // start is still high: the next frame must begin on its own.
        push_frame(4'd15, PATTERN);
        found = 1'b0;
        for (int w = 0; w < 6 && !found; w++) begin
          @(posedge clk);
          #1;
          if (tx === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
          n_fail++;
          $display("FAIL restart: tx=%b, required a start bit within 6 cycles of done", tx);
        end
        e_cyc = cyc - 1;
        start = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    bit eb;
    launch(8'd1, 4'd15, PATTERN);
    start = 1'b0;
    // Bits 0..22 are start, size and bytes 0-1 plus bits 7,6 of byte 2;
    // bit 23 is bit 5 of byte 2.
    repeat (23 * 2 + 1) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (tx !== 1'b0 || busy !== 1'b0 || crcout !== 8'h00 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: tx=%b busy=%b crc=%h done=%b, required 0 0 00 0", tx, busy, crcout, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || tx !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_hold: done=%b tx=%b, required 0 0", done, tx);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset_after: done=%b busy=%b, required 0 0", done, busy);
      end
    end
    $display("reset mid-frame at cycle %0d, line idle", cyc);
    launch(8'd0, 4'd1, {8'hA5, 8'h3C, 112'd0});
    start = 1'b0;
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      @(posedge clk);
      #1;
      n_checks++;
      if (tx !== eb || busy !== 1'b1 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_bit: cycle %0d tx=%b busy=%b done=%b, required tx=%b busy=1 done=0", cyc, tx, busy, done, eb);
      end
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b1 || crcout !== exp_crc) begin
      n_fail++;
      $display("FAIL post_reset_done: done=%b crc=%h, required 1 %h", done, crcout, exp_crc);
    end
    $display("frame after reset size=1 data=A5 3C ended, crc=%h", crcout);
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_one_byte();
    test_back_to_back();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
